// File: rtl/riscv_if_pkg.sv
// riscv_if_pkg: shared constants and the IF/ID register payload type for the fetch stage
package riscv_if_pkg;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES  = 32'd4;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;
endpackage

// File: rtl/instr_fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID output register with reset, flush, load and stall-hold rules
// Ports: CLK, RESET_N (sync, active-low), flush, load, ready (decode accepts),
//        inst_d/pc_d (captured on load), q (registered inst, pc, valid)
module if_id_reg
  import riscv_if_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        flush,
  input  logic        load,
  input  logic        ready,
  input  logic [31:0] inst_d,
  input  logic [31:0] pc_d,
  output if_id_t      q
);
  always_ff @(posedge CLK) begin
    if (!RESET_N) q <= '{inst: NOP_INSTR, pc: 32'd0, valid: 1'b0};
    else if (flush) q.valid <= 1'b0;
    else if (load) q <= '{inst: inst_d, pc: pc_d, valid: 1'b1};
    else q.valid <= q.valid & ~ready;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, next-PC mux and ROM fetch feeding a valid/ready IF/ID register
// Ports: CLK, RESET_N (sync, active-low), fetch_en, redirect, redirect_pc,
//        address (ROM word address), dsalida (ROM data), inst, inst_pc, inst_valid,
//        inst_ready, pc (debug), misalign (only with IFU_MISALIGN_TRAP_EN)
// Macro IFU_MISALIGN_TRAP_EN: misaligned redirect halts fetch and raises misalign;
// otherwise the low two redirect bits are masked off.
module instr_fetch_unit
  import riscv_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dsalida,
  output logic [DATA_W-1:0] inst,
  output logic [31:0]       inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  output logic [31:0]       pc
);
  if_id_t q;
  logic advance;
  logic [31:0] target;
`ifdef IFU_MISALIGN_TRAP_EN
  assign target  = redirect_pc;
  assign advance = fetch_en & (~q.valid | inst_ready) & ~misalign;
  always_ff @(posedge CLK) begin
    if (!RESET_N) misalign <= 1'b0;
    else if (redirect) misalign <= |redirect_pc[1:0];
  end
`else
  assign target  = redirect_pc & ~32'h3;
  assign advance = fetch_en & (~q.valid | inst_ready);
`endif
  assign address = pc[ADDR_W+1:2];
  always_ff @(posedge CLK) begin
    if (!RESET_N) pc <= RESET_PC;
    else if (redirect) pc <= target;
    else if (advance) pc <= pc + INSTR_BYTES;
  end
  if_id_reg u_if_id (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .flush  (redirect),
    .load   (advance),
    .ready  (inst_ready),
    .inst_d (dsalida),
    .pc_d   (pc),
    .q      (q)
  );
  assign inst       = q.inst;
  assign inst_pc    = q.pc;
  assign inst_valid = q.valid;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random checks of instr_fetch_unit against a behavioural fetch model
module tb_instr_fetch_unit;
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [9:0]  address;
  logic [31:0] dsalida;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] pc;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        misalign;
`endif
  logic [31:0] rom [1024];
  int tests = 0;
  int fails = 0;
  logic [31:0] m_pc = 32'd0, m_inst = 32'h13, m_ipc = 32'd0;
  logic        m_v = 1'b0, m_mis = 1'b0;

  instr_fetch_unit dut (
    .CLK(CLK), .RESET_N(RESET_N), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .address(address), .dsalida(dsalida), .inst(inst),
    .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
`ifdef IFU_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .pc(pc)
  );

  always #5 CLK = ~CLK;
  assign dsalida = rom[address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rn, input logic fe, input logic rd, input logic [31:0] rpc, input logic rdy);
    RESET_N = rn; fetch_en = fe; redirect = rd; redirect_pc = rpc; inst_ready = rdy;
    if (!rn) begin
      m_pc = 32'd0; m_v = 1'b0; m_inst = 32'h13; m_ipc = 32'd0; m_mis = 1'b0;
    end else if (rd) begin
      m_v = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      m_mis = (rpc % 4) != 0;
      m_pc = rpc;
`else
      m_pc = rpc - (rpc % 4);
`endif
    end else if (fe && (!m_v || rdy) && !m_mis) begin
      m_inst = rom[(m_pc / 4) % 1024];
      m_ipc = m_pc;
      m_v = 1'b1;
      m_pc = m_pc + 4;
    end else if (!(m_v && !rdy)) begin
      m_v = 1'b0;
    end
    @(posedge CLK);
    #1;
    chk("pc", pc, m_pc);
    chk("address", {22'd0, address}, (m_pc / 4) % 1024);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_v});
    if (m_v || !rn) begin
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_ipc);
    end
`ifdef IFU_MISALIGN_TRAP_EN
    chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0] = 32'h10000497;
    rom[1] = 32'h00048493;
    rom[2] = 32'h0004a083;
    rom[3] = 32'hff80a083;
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    chk("rst_inst", inst, 32'h00000013);
    // test 1: steady stream
    step(1, 1, 0, 0, 1);
    chk("t1_inst", inst, 32'h10000497);
    chk("t1_ipc", inst_pc, 32'd0);
    chk("t1_valid", {31'd0, inst_valid}, 32'd1);
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    chk("t1_ipc4", inst_pc, 32'd12);
    chk("t1_inst4", inst, 32'hff80a083);
    // test 2: stall
    step(0, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0);
      chk("t2_inst", inst, 32'h10000497);
      chk("t2_pc", pc, 32'd4);
      chk("t2_addr", {22'd0, address}, 32'd1);
    end
    step(1, 1, 0, 0, 1);
    chk("t2_release_ipc", inst_pc, 32'd4);
    // test 3: redirect during stall
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'h0000000C, 0);
    chk("t3_bubble", {31'd0, inst_valid}, 32'd0);
    step(1, 1, 0, 0, 1);
    chk("t3_inst", inst, 32'hff80a083);
    chk("t3_ipc", inst_pc, 32'd12);
    // test 4: address wrap
    step(1, 1, 1, 32'h00000FFC, 1);
    chk("t4_addr", {22'd0, address}, 32'd1023);
    step(1, 1, 0, 0, 1);
    chk("t4_pc", pc, 32'h1000);
    chk("t4_addr0", {22'd0, address}, 32'd0);
    step(1, 1, 0, 0, 1);
    chk("t4_inst", inst, 32'h10000497);
    chk("t4_ipc", inst_pc, 32'h1000);
    // test 5: reset wins over stall and redirect
    step(1, 1, 0, 0, 0);
    step(0, 1, 1, 32'h40, 0);
    chk("t5_pc", pc, 32'd0);
    chk("t5_valid", {31'd0, inst_valid}, 32'd0);
    chk("t5_inst", inst, 32'h00000013);
    // test 6: misaligned redirect
    step(1, 1, 0, 0, 1);
    step(1, 1, 1, 32'h00000006, 1);
`ifdef IFU_MISALIGN_TRAP_EN
    chk("t6_mis", {31'd0, misalign}, 32'd1);
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    chk("t6_halt", {31'd0, inst_valid}, 32'd0);
    step(1, 1, 1, 32'd0, 1);
    chk("t6_clr", {31'd0, misalign}, 32'd0);
    step(1, 1, 0, 0, 1);
    chk("t6_inst", inst, 32'h10000497);
`else
    chk("t6_pc", pc, 32'd4);
    step(1, 1, 0, 0, 1);
    chk("t6_ipc", inst_pc, 32'd4);
`endif
    // random phase
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom;
      step($urandom_range(0, 39) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) ? r : {20'd0, r[11:0]}, $urandom_range(0, 9) < 7);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
